// File: rtl/jpeg_sched_pkg.sv
// Shared types for the JPEG quantizer scheduler: component tags, FSM states,
// coefficient/block types and the MCU slot-to-component map.
package jpeg_sched_pkg;

    typedef enum logic [1:0] {
        COMP_Y  = 2'd0,
        COMP_CB = 2'd1,
        COMP_CR = 2'd2
    } comp_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_DRAIN
    } sched_state_t;

    typedef logic signed [10:0] coeff_t;
    typedef coeff_t [0:7][0:7] block_t;

    // 4:4:4 walks Y,Cb,Cr; 4:2:0 walks Y,Y,Y,Y,Cb,Cr
    function automatic comp_t slot_comp(input logic [2:0] slot, input logic sub420);
        comp_t c;
        if (sub420) begin
            c = (slot < 3'd4) ? COMP_Y : ((slot == 3'd4) ? COMP_CB : COMP_CR);
        end else begin
            c = (slot == 3'd0) ? COMP_Y : ((slot == 3'd1) ? COMP_CB : COMP_CR);
        end
        return c;
    endfunction

endpackage

// File: rtl/mcu_slot_counter.sv
// MCU slot counter: wraps after the last slot of the selected subsampling mode
// and reports which component owns the current (or just-cleared) slot.
module mcu_slot_counter
    import jpeg_sched_pkg::*;
#(
    parameter int unsigned SUBSAMPLE = 0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  i_advance,
    input  logic  i_clear,
    output comp_t o_comp,
    output logic  o_last
);

    localparam logic       SUB420    = (SUBSAMPLE != 0);
    localparam logic [2:0] LAST_SLOT = (SUBSAMPLE != 0) ? 3'd5 : 3'd2;

    logic [2:0] r_slot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot <= '0;
        end else if (i_clear) begin
            r_slot <= '0;
        end else if (i_advance) begin
            r_slot <= (r_slot == LAST_SLOT) ? '0 : r_slot + 3'd1;
        end
    end

    // A clear in this cycle already selects slot 0, so an acceptance alongside it is a Y block
    assign o_comp = i_clear ? COMP_Y : slot_comp(r_slot, SUB420);
    assign o_last = (r_slot == LAST_SLOT);

endmodule

// File: rtl/quant_block_scheduler.sv
// Shares one 8x8 quantizer between the Y/Cb/Cr streams in MCU order, launching
// each accepted block and presenting the result downstream over valid/ready.
module quant_block_scheduler
    import jpeg_sched_pkg::*;
#(
    parameter int unsigned SUBSAMPLE   = 0,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_start,
    input  logic [2:0]   req_valid,
    output logic [2:0]   req_ready,
    input  block_t [2:0] req_block,
    output logic         q_enable,
    output block_t       q_Z,
    output logic         q_chroma,
    input  logic         q_out_enable,
    input  block_t       q_Q,
    output logic         out_valid,
    input  logic         out_ready,
    output block_t       out_block,
    output logic [1:0]   out_comp,
    output logic         mcu_done,
    output logic         err_timeout
);

    sched_state_t r_state, w_next;

    comp_t       w_slot_comp;
    logic        w_slot_last;
    comp_t       r_comp;
    comp_t       r_out_comp;
    block_t      r_blk;
    block_t      r_out;
    logic [31:0] r_wd;
    logic        r_err;
    logic        r_fs_pend;

    logic w_accept, w_done, w_timeout, w_handshake, w_to_idle, w_clear;

    assign w_accept    = |req_ready;
    assign w_done      = (r_state == ST_WAIT) && q_out_enable;
    assign w_timeout   = (r_state == ST_WAIT) && !q_out_enable && ((r_wd + 32'd1) == 32'(TIMEOUT_CYC));
    assign w_handshake = (r_state == ST_DRAIN) && out_ready;
    assign w_to_idle   = w_timeout || w_handshake;
    // frame_start acts at once in IDLE; elsewhere it lands on the transition back to IDLE
    assign w_clear     = (r_state == ST_IDLE) ? frame_start : (w_to_idle && (r_fs_pend || frame_start));

    mcu_slot_counter #(
        .SUBSAMPLE (SUBSAMPLE)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .i_advance (w_to_idle),
        .i_clear   (w_clear),
        .o_comp    (w_slot_comp),
        .o_last    (w_slot_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next = ST_LAUNCH;
            ST_LAUNCH: w_next = ST_WAIT;
            ST_WAIT: begin
                if (w_done) begin
                    w_next = ST_DRAIN;
                end else if (w_timeout) begin
                    w_next = ST_IDLE;
                end
            end
            ST_DRAIN:  if (out_ready) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if ((r_state == ST_IDLE) && !rst) begin
            req_ready[w_slot_comp] = req_valid[w_slot_comp];
        end
        q_enable  = (r_state == ST_LAUNCH);
        q_chroma  = ((r_state == ST_LAUNCH) || (r_state == ST_WAIT)) && (r_comp != COMP_Y);
        out_valid = (r_state == ST_DRAIN);
        mcu_done  = w_handshake && w_slot_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blk      <= '0;
            r_comp     <= COMP_Y;
            r_out      <= '0;
            r_out_comp <= COMP_Y;
            r_wd       <= '0;
            r_err      <= 1'b0;
            r_fs_pend  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_blk  <= req_block[w_slot_comp];
                r_comp <= w_slot_comp;
            end
            if (r_state == ST_LAUNCH) begin
                r_wd <= '0;
            end else if (r_state == ST_WAIT) begin
                r_wd <= r_wd + 32'd1;
            end
            if (w_done) begin
                r_out      <= q_Q;
                r_out_comp <= r_comp;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (w_to_idle) begin
                r_fs_pend <= 1'b0;
            end else if (frame_start && (r_state != ST_IDLE)) begin
                r_fs_pend <= 1'b1;
            end
        end
    end

    assign q_Z         = r_blk;
    assign out_block   = r_out;
    assign out_comp    = r_out_comp;
    assign err_timeout = r_err;

endmodule

// File: tb/tb_quant_block_scheduler.sv
// Bench for quant_block_scheduler: a 4:4:4 and a 4:2:0 instance, each with an
// inverting stub quantizer; accepted blocks feed a scoreboard checked against outputs.
module tb_quant_block_scheduler;
    import jpeg_sched_pkg::*;

    typedef struct {
        logic [1:0] comp;
        block_t     blk;
        logic       mcu;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fs  = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rv0, rr0, rv1, rr1;
    block_t [2:0] rb0, rb1;
    logic qen0, qch0, qoe0, ov0, ordy0, md0, err0;
    logic qen1, qch1, qoe1, ov1, ordy1, md1, err1;
    block_t qz0, qq0, ob0, qz1, qq1, ob1;
    logic [1:0] oc0, oc1;

    quant_block_scheduler #(.SUBSAMPLE(0), .TIMEOUT_CYC(64)) dut0 (
        .clk(clk), .rst(rst), .frame_start(fs), .req_valid(rv0), .req_ready(rr0),
        .req_block(rb0), .q_enable(qen0), .q_Z(qz0), .q_chroma(qch0),
        .q_out_enable(qoe0), .q_Q(qq0), .out_valid(ov0), .out_ready(ordy0),
        .out_block(ob0), .out_comp(oc0), .mcu_done(md0), .err_timeout(err0));

    quant_block_scheduler #(.SUBSAMPLE(1), .TIMEOUT_CYC(64)) dut1 (
        .clk(clk), .rst(rst), .frame_start(fs), .req_valid(rv1), .req_ready(rr1),
        .req_block(rb1), .q_enable(qen1), .q_Z(qz1), .q_chroma(qch1),
        .q_out_enable(qoe1), .q_Q(qq1), .out_valid(ov1), .out_ready(ordy1),
        .out_block(ob1), .out_comp(oc1), .mcu_done(md1), .err_timeout(err1));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit fmax = 1'b0;
    bit never0 = 1'b0;
    int cnt0 = 0;
    int cnt1 = 0;
    block_t mx_in, mx_out;

    obs_t   obs0[$], obs1[$];
    block_t expb0[$], expb1[$];
    logic   obsch0[$];
    int     acc0 = 0, acc1 = 0;
    int     acccyc0[$], qencyc0[$];

    function automatic block_t gen(input int s, input int n);
        block_t b;
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 8; k++)
                b[r][k] = coeff_t'(((s * 311 + n * 37 + r * 13 + k * 7) % 2048) - 1024);
        return b;
    endfunction

    // Stub quantizer: result = bitwise inverse of q_Z, three cycles after launch
    always @(negedge clk) begin
        qoe0 = 1'b0; qq0 = '0; qoe1 = 1'b0; qq1 = '0;
        if (rst) begin
            cnt0 = 0; cnt1 = 0;
        end else begin
            if (cnt0 > 0) begin cnt0--; if (cnt0 == 0) begin qoe0 = 1'b1; qq0 = ~qz0; end end
            if (qen0 && !never0) cnt0 = 3;
            if (cnt1 > 0) begin cnt1--; if (cnt1 == 0) begin qoe1 = 1'b1; qq1 = ~qz1; end end
            if (qen1) cnt1 = 3;
        end
    end

    // Request data changes every cycle so each accepted block is distinct
    always @(posedge clk) begin
        cyc++;
        #2;
        for (int c = 0; c < 3; c++) begin
            rb0[c] = fmax ? mx_in : gen(c, cyc);
            rb1[c] = gen(c + 3, cyc);
        end
    end

    always @(negedge clk) begin
        obs_t o;
        if (!rst) begin
            for (int c = 0; c < 3; c++) begin
                if (rr0[c] && rv0[c]) begin acc0++; expb0.push_back(~rb0[c]); acccyc0.push_back(cyc); end
                if (rr1[c] && rv1[c]) begin acc1++; expb1.push_back(~rb1[c]); end
            end
            if (qen0) begin obsch0.push_back(qch0); qencyc0.push_back(cyc); end
            if (ov0 && ordy0) begin o.comp = oc0; o.blk = ob0; o.mcu = md0; obs0.push_back(o); end
            if (ov1 && ordy1) begin o.comp = oc1; o.blk = ob1; o.mcu = md1; obs1.push_back(o); end
        end
    end

    task automatic clear_q();
        obs0.delete(); obs1.delete(); expb0.delete(); expb1.delete();
        obsch0.delete(); acccyc0.delete(); qencyc0.delete();
    endtask

    task automatic run0(input int n_acc, input int n_out, input int budget, output bit ok);
        int tgt;
        tgt = acc0 + n_acc;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (acc0 >= tgt) rv0 = '0;
            if (acc0 >= tgt && obs0.size() >= n_out) begin ok = 1'b1; break; end
        end
        rv0 = '0;
    endtask

    task automatic run1(input int n_acc, input int n_out, input int budget, output bit ok);
        int tgt;
        tgt = acc1 + n_acc;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (acc1 >= tgt) rv1 = '0;
            if (acc1 >= tgt && obs1.size() >= n_out) begin ok = 1'b1; break; end
        end
        rv1 = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; fs = 1'b0; rv0 = 3'b111; rv1 = 3'b111; ordy0 = 1'b1; ordy1 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (rr0 !== 3'b000) begin errors++; $display("FAIL reset_req_ready0 got %b exp 000", rr0); end
        checks++; if (rr1 !== 3'b000) begin errors++; $display("FAIL reset_req_ready1 got %b exp 000", rr1); end
        checks++; if (qen0 !== 1'b0) begin errors++; $display("FAIL reset_q_enable got %b exp 0", qen0); end
        checks++; if (qch0 !== 1'b0) begin errors++; $display("FAIL reset_q_chroma got %b exp 0", qch0); end
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", ov0); end
        checks++; if (md0 !== 1'b0) begin errors++; $display("FAIL reset_mcu_done got %b exp 0", md0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err_timeout got %b exp 0", err0); end
        checks++; if (qz0 !== '0) begin errors++; $display("FAIL reset_q_Z got %h exp 0", qz0); end
        checks++; if (ob0 !== '0) begin errors++; $display("FAIL reset_out_block got %h exp 0", ob0); end
        checks++; if (oc0 !== 2'd0) begin errors++; $display("FAIL reset_out_comp got %0d exp 0", oc0); end
        @(posedge clk); #1;
        rv0 = '0; rv1 = '0; rst = 1'b0;
    endtask

    task automatic test_444();
        logic [1:0] ec [6];
        logic em [6];
        logic ech [6];
        obs_t o;
        block_t eb;
        bit ok;
        ec = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        em = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        ech = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        clear_q();
        rv0 = 3'b111; ordy0 = 1'b1;
        run0(6, 6, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL s444_done got acc=%0d out=%0d exp 6/6", acc0, obs0.size()); end
        checks++; if (obs0.size() != 6) begin errors++; $display("FAIL s444_count got %0d exp 6", obs0.size()); end
        if (acccyc0.size() >= 2 && qencyc0.size() >= 1) begin
            checks++; if (qencyc0[0] - acccyc0[0] != 1) begin errors++; $display("FAIL s444_launch_lat got %0d exp 1", qencyc0[0] - acccyc0[0]); end
            checks++; if (acccyc0[1] - acccyc0[0] != 6) begin errors++; $display("FAIL s444_period got %0d exp 6", acccyc0[1] - acccyc0[0]); end
        end
        for (int i = 0; i < 6; i++) begin
            if (obs0.size() == 0 || expb0.size() == 0 || obsch0.size() == 0) break;
            o = obs0.pop_front(); eb = expb0.pop_front();
            checks++; if (o.comp !== ec[i]) begin errors++; $display("FAIL s444_comp[%0d] got %0d exp %0d", i, o.comp, ec[i]); end
            checks++; if (o.mcu !== em[i]) begin errors++; $display("FAIL s444_mcu[%0d] got %b exp %b", i, o.mcu, em[i]); end
            checks++; if (o.blk !== eb) begin errors++; $display("FAIL s444_blk[%0d] got %h exp %h", i, o.blk, eb); end
            checks++; if (obsch0[i] !== ech[i]) begin errors++; $display("FAIL s444_chroma[%0d] got %b exp %b", i, obsch0[i], ech[i]); end
        end
    endtask

    task automatic test_420();
        logic [1:0] ec [6];
        logic em [6];
        obs_t o;
        block_t eb;
        bit ok;
        ec = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
        em = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        clear_q();
        rv1 = 3'b110; ordy1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (rr1 !== 3'b000) begin errors++; $display("FAIL s420_no_chroma_first got %b exp 000", rr1); end
        end
        @(posedge clk); #1;
        rv1 = 3'b111;
        run1(6, 6, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL s420_done got acc=%0d out=%0d exp 6/6", acc1, obs1.size()); end
        for (int i = 0; i < 6; i++) begin
            if (obs1.size() == 0 || expb1.size() == 0) break;
            o = obs1.pop_front(); eb = expb1.pop_front();
            checks++; if (o.comp !== ec[i]) begin errors++; $display("FAIL s420_comp[%0d] got %0d exp %0d", i, o.comp, ec[i]); end
            checks++; if (o.mcu !== em[i]) begin errors++; $display("FAIL s420_mcu[%0d] got %b exp %b", i, o.mcu, em[i]); end
            checks++; if (o.blk !== eb) begin errors++; $display("FAIL s420_blk[%0d] got %h exp %h", i, o.blk, eb); end
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        obs_t o;
        clear_q();
        fmax = 1'b1; ordy0 = 1'b0;
        @(posedge clk); #1;
        rv0 = 3'b001;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ov0) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL bp_reach_drain got out_valid=%b exp 1", ov0); end
        @(posedge clk); #1;
        rv0 = 3'b111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (ov0 !== 1'b1 || ob0 !== mx_out || rr0 !== 3'b000) begin
                errors++; $display("FAIL bp_hold[%0d] got valid=%b ready=%b blk=%h exp 1 000 %h", i, ov0, rr0, ob0, mx_out);
            end
            @(posedge clk); #1;
        end
        ordy0 = 1'b1; rv0 = '0; fmax = 1'b0;
        @(negedge clk);
        checks++; if (ov0 !== 1'b1 || md0 !== 1'b0) begin errors++; $display("FAIL bp_release got valid=%b mcu=%b exp 1 0", ov0, md0); end
        @(negedge clk);
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL bp_after got valid=%b exp 0", ov0); end
        checks++; if (obs0.size() != 1) begin errors++; $display("FAIL bp_count got %0d exp 1", obs0.size()); end
        if (obs0.size() > 0) begin
            o = obs0.pop_front();
            checks++; if (o.blk !== mx_out || o.comp !== 2'd0) begin errors++; $display("FAIL bp_data got comp=%0d blk=%h exp 0 %h", o.comp, o.blk, mx_out); end
        end
    endtask

    task automatic test_timeout();
        logic [1:0] ec [2];
        logic em [2];
        obs_t o;
        bit ok;
        bit saw_valid;
        int t0;
        ec = '{2'd2, 2'd0};
        em = '{1'b1, 1'b0};
        clear_q();
        never0 = 1'b1;
        rv0 = 3'b010;
        run0(1, 0, 20, ok);
        checks++; if (!ok || acccyc0.size() == 0) begin errors++; $display("FAIL to_accept_cb got acc=%0d exp 1", acccyc0.size()); end
        t0 = (acccyc0.size() > 0) ? acccyc0[0] : cyc;
        saw_valid = 1'b0;
        while (cyc < t0 + 70) begin
            @(negedge clk);
            if (ov0) saw_valid = 1'b1;
            if (cyc == t0 + 65) begin
                checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL to_early got err=%b exp 0", err0); end
            end
            if (cyc == t0 + 66) begin
                checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL to_fire got err=%b exp 1", err0); end
            end
        end
        checks++; if (saw_valid) begin errors++; $display("FAIL to_no_output got out_valid=1 exp 0"); end
        never0 = 1'b0;
        @(posedge clk); #1;
        rv0 = 3'b111;
        run0(2, 2, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL to_resume got out=%0d exp 2", obs0.size()); end
        for (int i = 0; i < 2; i++) begin
            if (obs0.size() == 0 || expb0.size() < 2 - i) break;
            o = obs0.pop_front();
            checks++; if (o.comp !== ec[i] || o.mcu !== em[i]) begin errors++; $display("FAIL to_next[%0d] got comp=%0d mcu=%b exp %0d %b", i, o.comp, o.mcu, ec[i], em[i]); end
            checks++; if (o.blk !== expb0[expb0.size() - 2 + i]) begin errors++; $display("FAIL to_blk[%0d] got %h", i, o.blk); end
        end
        checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL to_sticky got err=%b exp 1", err0); end
    endtask

    task automatic test_frame_start();
        logic [1:0] ec [2];
        obs_t o;
        block_t eb;
        bit ok;
        ec = '{2'd1, 2'd0};
        clear_q();
        rv0 = 3'b010;
        run0(1, 0, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fs_accept_cb got acc=%0d exp 1", acc0); end
        @(posedge clk); #1;
        fs = 1'b1;
        @(posedge clk); #1;
        fs = 1'b0;
        rv0 = 3'b111;
        run0(1, 2, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fs_done got out=%0d exp 2", obs0.size()); end
        for (int i = 0; i < 2; i++) begin
            if (obs0.size() == 0 || expb0.size() == 0) break;
            o = obs0.pop_front(); eb = expb0.pop_front();
            checks++; if (o.comp !== ec[i] || o.mcu !== 1'b0) begin errors++; $display("FAIL fs_order[%0d] got comp=%0d mcu=%b exp %0d 0", i, o.comp, o.mcu, ec[i]); end
            checks++; if (o.blk !== eb) begin errors++; $display("FAIL fs_blk[%0d] got %h exp %h", i, o.blk, eb); end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        block_t eb;
        bit ok;
        clear_q();
        rv0 = 3'b010;
        run0(1, 0, 20, ok);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (qch0 !== 1'b1) begin errors++; $display("FAIL rm_pre_chroma got %b exp 1", qch0); end
        rv0 = 3'b111;
        rst = 1'b1;
        #1;
        checks++; if (qch0 !== 1'b0 || qen0 !== 1'b0 || ov0 !== 1'b0 || md0 !== 1'b0) begin
            errors++; $display("FAIL rm_ctrl got chroma=%b en=%b valid=%b mcu=%b exp 0 0 0 0", qch0, qen0, ov0, md0);
        end
        checks++; if (err0 !== 1'b0 || rr0 !== 3'b000) begin errors++; $display("FAIL rm_err_ready got err=%b ready=%b exp 0 000", err0, rr0); end
        checks++; if (qz0 !== '0 || ob0 !== '0 || oc0 !== 2'd0) begin errors++; $display("FAIL rm_data got comp=%0d z=%h", oc0, qz0); end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_q();
        run0(1, 1, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rm_fresh_done got out=%0d exp 1", obs0.size()); end
        if (obs0.size() > 0 && expb0.size() > 0) begin
            o = obs0.pop_front(); eb = expb0.pop_front();
            checks++; if (o.comp !== 2'd0 || o.blk !== eb) begin errors++; $display("FAIL rm_fresh got comp=%0d blk=%h exp 0 %h", o.comp, o.blk, eb); end
        end
    endtask

    initial begin
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 8; k++) begin
                mx_in[r][k]  = coeff_t'(-1024);
                mx_out[r][k] = coeff_t'(1023);
            end
        test_reset();
        test_444();
        test_420();
        test_backpressure();
        test_timeout();
        test_frame_start();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got cycle %0d exp completion", cyc);
        $fatal(1);
    end

endmodule
